ptw_mem_arbiter: RTL and testbench
==================================

// Module: ptw_mem_arbiter
// PURPOSE
//  Shares one page-table memory port between the instruction-side and data-side MMU walkers.
//  - Sits downstream of each MMU's walker interface (mem_addr/mem_read in, mem_data/mem_ready out).
//  - Upstream of the memory fabric, which uses a valid/ready request channel and a valid response channel.
//  - Round-robin arbitration, one outstanding walk read, response timeout with fault conversion.
// PARAMETERS
//  ADDR_W     48   physical address width of PTE reads
//  DATA_W     48   PTE width
//  TIMEOUT    255  WAIT cycles without response before abort (1..2^TMO_W-1)
//  TMO_W      8    timeout counter width
// PORTS
//  clk              in   1       single clock, rising edge
//  reset_n          in   1       asynchronous, active-low reset
//  c0_mem_addr      in   ADDR_W  client 0 (I-MMU) PTE address
//  c0_mem_read      in   1       client 0 walk read request (level, held until mem_ready)
//  c0_mem_data      out  DATA_W  client 0 PTE data, valid with c0_mem_ready
//  c0_mem_ready     out  1       client 0 one-cycle completion pulse
//  c1_mem_addr/c1_mem_read/c1_mem_data/c1_mem_ready  same, client 1 (D-MMU)
//  bus_req_valid    out  1       request to memory fabric
//  bus_req_ready    in   1       fabric accepts request
//  bus_req_addr     out  ADDR_W  latched PTE address
//  bus_rsp_valid    in   1       response strobe (in-order)
//  bus_rsp_data     in   DATA_W  response PTE
//  bus_rsp_error    in   1       response carries bus error (qualified by bus_rsp_valid)
//  walk_error       out  1       one-cycle pulse on timeout or bus error
//  walk_error_client out 1       client id of last walk_error; held until next error
//  busy             out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; last_grant=1 (client 0 wins first tie); stale=0; tmo=0.
//  States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: if c0_mem_read|c1_mem_read, grant.
//    - One requester: grant it.
//    - Both: grant !last_grant.
//    - Latch addr and client id, last_grant<=grant, -> ISSUE.
//  - ISSUE: bus_req_valid=1, bus_req_addr stable.
//    - On bus_req_ready: -> WAIT, tmo<=0.
//    - No timeout while in ISSUE.
//  - WAIT:
//    - bus_rsp_valid & !stale: latch data (0 if bus_rsp_error; error also pulses walk_error), -> RESP.
//    - bus_rsp_valid & stale: discard, stale<=0, stay.
//    - Otherwise tmo++. At tmo==TIMEOUT: data<=0, walk_error pulse, stale<=1, -> RESP.
//    - A response in the same cycle as the timeout wins; no error, stale unchanged.
//  - RESP: cN_mem_ready=1 for exactly this cycle, with cN_mem_data = latched data (registered outputs).
//    - If the granted client dropped mem_read while pending, suppress the pulse; the result is discarded.
//    - -> IDLE. No arbitration in RESP, so the client's next-level request is seen in IDLE next cycle.
//  Latency (zero-wait fabric):
//    - request seen in IDLE cycle N; req handshake N+1.
//    - response in cycle M; mem_ready pulse M+1; IDLE M+2.
//  Fault conversion: zero data has PTE valid bit [3]=0, so the MMU raises page_fault. No extra wire needed.
//  Stale handling:
//    - stale stays set across IDLE/ISSUE.
//    - The first response received afterwards (any state) is dropped. This relies on in-order fabric.
//    - bus_rsp_valid outside WAIT with stale=0 is ignored.
//  Address or mem_read changes after latch: ignored for the current transaction.
//  Mid-operation reset: transaction abandoned, all state to reset values. Fabric shares reset_n.
//  mem_data outputs are zero except in the RESP cycle of the owning client.
// STRUCTURE
//  Shared package pentary_mmu_pkg:
//    - ptw_state_t {IDLE,ISSUE,WAIT,RESP}
//    - CLIENT_IMMU=0, CLIENT_DMMU=1
//    - PTE_VALID_BIT=3
//    - PHYS_ADDR_W=48
//  Sub-module ptw_rr_arb2:
//    - 2-way round-robin grant.
//    - Inputs: req[1:0], last_grant. Output: grant id, combinational.
//  Top holds the FSM, latches, timeout counter and stale flag.
// TESTING
//  1. Single request:
//     - Stimulus: c0_mem_read=1, addr 0x1000; req_ready=1; rsp 3 cycles after handshake, data 0xA00F.
//     - Response: bus_req_addr=0x1000; c0_mem_ready pulses once, the cycle after rsp, data 0xA00F; c1_mem_ready stays 0.
//  2. Tie-break after reset:
//     - Stimulus: c0 and c1 request in the same cycle.
//     - Response: c0 served first, then c1. On the next tie, c0 wins again (last_grant=1).
//  3. Timeout:
//     - Stimulus: TIMEOUT=8, no rsp; late rsp 0x123 arrives after the abort; client 1 then requests.
//     - Response: after 8 WAIT cycles, walk_error pulses and c0_mem_ready pulses with data 0. The late 0x123 is dropped; client 1 receives its own data.
//  4. Bus error:
//     - Stimulus: bus_rsp_valid with bus_rsp_error=1, data 0xFFFF, granted client 1.
//     - Response: c1_mem_data=0, walk_error=1, walk_error_client=1.
//  5. Back-pressure:
//     - Stimulus: bus_req_ready held low 20 cycles.
//     - Response: req_valid and addr stable throughout; no walk_error; normal completion after ready.
//  6. Reset mid-operation:
//     - Stimulus: reset_n low during WAIT, then c0 re-requests.
//     - Response: outputs 0 and busy=0 during reset; the next request completes normally with no stale drop.

Source files
------------

// File: rtl/pentary_mmu_pkg.sv
// Shared MMU types and constants: walker FSM states, client ids and PTE layout.
package pentary_mmu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } ptw_state_t;

   localparam logic CLIENT_IMMU   = 1'b0;
   localparam logic CLIENT_DMMU   = 1'b1;
   localparam int   PTE_VALID_BIT = 3;
   localparam int   PHYS_ADDR_W   = 48;

endpackage

// File: rtl/ptw_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the client not granted last.
module ptw_rr_arb2
   import pentary_mmu_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant
);

   always_comb begin
      if (req == 2'b11) begin
         grant = ~last_grant;
      end else if (req[1]) begin
         grant = CLIENT_DMMU;
      end else begin
         grant = CLIENT_IMMU;
      end
   end

endmodule

// File: rtl/ptw_mem_arbiter.sv
// Shares one page-table memory port between the I-MMU and D-MMU walkers: one outstanding
// read, round-robin grant, response timeout converted into an all-zero (invalid) PTE.
module ptw_mem_arbiter
   import pentary_mmu_pkg::*;
#(
   parameter int ADDR_W  = PHYS_ADDR_W,
   parameter int DATA_W  = 48,
   parameter int TIMEOUT = 255,
   parameter int TMO_W   = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] c0_mem_addr,
   input  logic              c0_mem_read,
   output logic [DATA_W-1:0] c0_mem_data,
   output logic              c0_mem_ready,
   input  logic [ADDR_W-1:0] c1_mem_addr,
   input  logic              c1_mem_read,
   output logic [DATA_W-1:0] c1_mem_data,
   output logic              c1_mem_ready,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic [ADDR_W-1:0] bus_req_addr,
   input  logic              bus_rsp_valid,
   input  logic [DATA_W-1:0] bus_rsp_data,
   input  logic              bus_rsp_error,
   output logic              walk_error,
   output logic              walk_error_client,
   output logic              busy
);

   ptw_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              client_q;
   logic              last_grant_q;
   logic              stale_q;
   logic [TMO_W-1:0]  tmo_q;
   logic              grant;
   logic              latch_req, rsp_take, tmo_fire, tmo_inc, finish;
   logic [DATA_W-1:0] result;

   ptw_rr_arb2 u_arb (
      .req        ({c1_mem_read, c0_mem_read}),
      .last_grant (last_grant_q),
      .grant      (grant)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      latch_req = 1'b0;
      rsp_take  = 1'b0;
      tmo_fire  = 1'b0;
      tmo_inc   = 1'b0;
      case (state_q)
         IDLE: begin
            if (c0_mem_read || c1_mem_read) begin
               latch_req = 1'b1;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            if (bus_req_ready) state_d = WAIT;
         end
         WAIT: begin
            // A response always beats the timeout; a stale one is only swallowed here.
            if (bus_rsp_valid) begin
               if (!stale_q) begin
                  rsp_take = 1'b1;
                  state_d  = RESP;
               end
            end else if (tmo_q == TMO_W'(TIMEOUT)) begin
               tmo_fire = 1'b1;
               state_d  = RESP;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign finish        = rsp_take | tmo_fire;
   assign result        = (rsp_take && !bus_rsp_error) ? bus_rsp_data : '0;
   assign bus_req_valid = (state_q == ISSUE);
   assign bus_req_addr  = addr_q;
   assign busy          = (state_q != IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q            <= '0;
         client_q          <= CLIENT_IMMU;
         last_grant_q      <= CLIENT_DMMU;
         stale_q           <= 1'b0;
         tmo_q             <= '0;
         c0_mem_ready      <= 1'b0;
         c1_mem_ready      <= 1'b0;
         c0_mem_data       <= '0;
         c1_mem_data       <= '0;
         walk_error        <= 1'b0;
         walk_error_client <= 1'b0;
      end else begin
         c0_mem_ready <= 1'b0;
         c1_mem_ready <= 1'b0;
         c0_mem_data  <= '0;
         c1_mem_data  <= '0;
         walk_error   <= 1'b0;

         if (latch_req) begin
            addr_q       <= grant ? c1_mem_addr : c0_mem_addr;
            client_q     <= grant;
            last_grant_q <= grant;
         end

         if (state_q == ISSUE && bus_req_ready) tmo_q <= '0;
         else if (tmo_inc)                       tmo_q <= tmo_q + 1'b1;

         // The first response after an abort belongs to the aborted walk, whatever the state.
         if (bus_rsp_valid && stale_q) stale_q <= 1'b0;
         else if (tmo_fire)            stale_q <= 1'b1;

         if (finish) begin
            if (client_q == CLIENT_IMMU && c0_mem_read) begin
               c0_mem_ready <= 1'b1;
               c0_mem_data  <= result;
            end
            if (client_q == CLIENT_DMMU && c1_mem_read) begin
               c1_mem_ready <= 1'b1;
               c1_mem_data  <= result;
            end
            if (tmo_fire || bus_rsp_error) begin
               walk_error        <= 1'b1;
               walk_error_client <= client_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Scoreboard bench for ptw_mem_arbiter: a driver plays both walkers and the fabric, a monitor
// checks every completion pulse against expectations queued from a transaction-level model.
module tb_ptw_mem_arbiter;

   localparam int AW  = 48;
   localparam int DW  = 48;
   localparam int TMO = 8;

   typedef struct {
      bit          client;
      logic [47:0] data;
      bit          err;
      int          cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] c0_mem_addr = '0, c1_mem_addr = '0;
   logic          c0_mem_read = 1'b0, c1_mem_read = 1'b0;
   logic [DW-1:0] c0_mem_data, c1_mem_data;
   logic          c0_mem_ready, c1_mem_ready;
   logic          bus_req_valid;
   logic          bus_req_ready = 1'b0;
   logic [AW-1:0] bus_req_addr;
   logic          bus_rsp_valid = 1'b0;
   logic [DW-1:0] bus_rsp_data = '0;
   logic          bus_rsp_error = 1'b0;
   logic          walk_error, walk_error_client, busy;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   bit   m_last = 1'b1;
   bit   m_stale = 1'b0;

   ptw_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .TMO_W(8)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .c0_mem_addr       (c0_mem_addr),
      .c0_mem_read       (c0_mem_read),
      .c0_mem_data       (c0_mem_data),
      .c0_mem_ready      (c0_mem_ready),
      .c1_mem_addr       (c1_mem_addr),
      .c1_mem_read       (c1_mem_read),
      .c1_mem_data       (c1_mem_data),
      .c1_mem_ready      (c1_mem_ready),
      .bus_req_valid     (bus_req_valid),
      .bus_req_ready     (bus_req_ready),
      .bus_req_addr      (bus_req_addr),
      .bus_rsp_valid     (bus_rsp_valid),
      .bus_rsp_data      (bus_rsp_data),
      .bus_rsp_error     (bus_rsp_error),
      .walk_error        (walk_error),
      .walk_error_client (walk_error_client),
      .busy              (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic finish_test();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [47:0] rnd48();
      return {16'($urandom), 32'($urandom)};
   endfunction

   // One walk: request, optional back-pressure, then response / bus error / silence (timeout).
   task automatic walk(input bit r0, input bit r1, input logic [47:0] a0, input logic [47:0] a1,
                       input logic [47:0] rdata, input int bp, input int dly, input bit err,
                       input bit tmo, input bit junk, input bit drop);
      bit          w;
      logic [47:0] exp_addr;
      int          guard, exp_cyc;
      c0_mem_addr = a0;
      c1_mem_addr = a1;
      c0_mem_read = r0;
      c1_mem_read = r1;
      w        = (r0 && r1) ? !m_last : r1;
      m_last   = w;
      exp_addr = w ? a1 : a0;
      guard    = 0;
      @(negedge clk);
      while (!bus_req_valid && guard < 8) begin
         @(negedge clk);
         guard++;
      end
      check("req_valid_seen", bus_req_valid, 1'b1);
      if (!bus_req_valid) finish_test();
      check("req_addr", bus_req_addr, exp_addr);
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         check("req_hold", {walk_error, bus_req_valid, bus_req_addr}, {2'b01, exp_addr});
      end
      bus_req_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_req_ready = 1'b0;
      if (drop) begin
         if (w) c1_mem_read = 1'b0;
         else   c0_mem_read = 1'b0;
      end
      if (junk) begin
         bus_rsp_valid = 1'b1;
         bus_rsp_data  = 48'h123;
         step();
         bus_rsp_valid = 1'b0;
         m_stale       = 1'b0;
      end
      if (tmo) begin
         exp_cyc = cyc + TMO + 1;
         m_stale = 1'b1;
      end else begin
         for (int i = 1; i < dly; i++) step();
         bus_rsp_valid = 1'b1;
         bus_rsp_data  = rdata;
         bus_rsp_error = err;
         exp_cyc       = cyc + 1;
      end
      if (!drop) exp_q.push_back('{client: w, data: (err || tmo) ? 48'h0 : rdata,
                                   err: err || tmo, cyc: exp_cyc});
      if (!tmo) begin
         step();
         bus_rsp_valid = 1'b0;
         bus_rsp_error = 1'b0;
      end
      guard = 0;
      while (cyc < exp_cyc && guard < TMO + 20) begin
         step();
         guard++;
      end
      if (w) c1_mem_read = 1'b0;
      else   c0_mem_read = 1'b0;
   endtask

   // Late response for an aborted walk, delivered while no walk is pending.
   task automatic send_junk();
      c0_mem_read   = 1'b0;
      c1_mem_read   = 1'b0;
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = 48'h123;
      step();
      bus_rsp_valid = 1'b0;
      m_stale       = 1'b0;
      step();
      check("junk_idle_busy", busy, 1'b0);
   endtask

   task automatic reset_mid();
      int guard = 0;
      c0_mem_addr = 48'h2000;
      c0_mem_read = 1'b1;
      @(negedge clk);
      while (!bus_req_valid && guard < 8) begin
         @(negedge clk);
         guard++;
      end
      check("rst_req_valid", bus_req_valid, 1'b1);
      bus_req_ready = 1'b1;
      step();
      bus_req_ready = 1'b0;
      step();
      step();
      check("rst_pre_busy", busy, 1'b1);
      reset_n     = 1'b0;
      c0_mem_read = 1'b0;
      #1;
      check("rst_async_outputs", {busy, bus_req_valid, c0_mem_ready, c1_mem_ready,
                                  walk_error, walk_error_client}, 6'b0);
      step();
      @(negedge clk);
      check("rst_held_outputs", {busy, bus_req_valid, bus_req_addr, c0_mem_data, c1_mem_data},
            '0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      m_last  = 1'b1;
      m_stale = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (c0_mem_ready || c1_mem_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ready", {c1_mem_ready, c0_mem_ready}, 2'b00);
            end else begin
               e = exp_q.pop_front();
               check("ready_client", {c1_mem_ready, c0_mem_ready}, e.client ? 2'b10 : 2'b01);
               check("ready_cycle", cyc, e.cyc);
               check("rsp_data", e.client ? c1_mem_data : c0_mem_data, e.data);
               check("other_data", e.client ? c0_mem_data : c1_mem_data, 48'h0);
               check("walk_error", walk_error, e.err);
               if (e.err) check("walk_error_client", walk_error_client, e.client);
            end
         end else begin
            check("quiet", {walk_error, c0_mem_data, c1_mem_data}, '0);
         end
      end
   end

   initial begin : watchdog
      #500us;
      n_fail++;
      $display("FAIL watchdog: simulation did not finish, %0d expectations left", exp_q.size());
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1);
   end

   initial begin : stimulus
      int r, bp, dly;
      bit err, tmo, junk;
      step();
      step();
      @(negedge clk);
      check("reset_outputs", {busy, bus_req_valid, c0_mem_ready, c1_mem_ready, walk_error,
                              walk_error_client, c0_mem_data, c1_mem_data, bus_req_addr}, '0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // single request on the I-MMU
      walk(1, 0, 48'h1000, 48'h0, 48'hA00F, 0, 3, 0, 0, 0, 0);
      // tie after reset goes to c0, then c1, then the next tie to c0 again
      walk(1, 1, rnd48(), rnd48(), rnd48(), 0, 1, 0, 0, 0, 0);
      walk(0, 1, rnd48(), rnd48(), rnd48(), 0, 2, 0, 0, 0, 0);
      walk(1, 1, rnd48(), rnd48(), rnd48(), 1, 1, 0, 0, 0, 0);
      walk(0, 1, rnd48(), rnd48(), rnd48(), 0, 1, 0, 0, 0, 0);
      // timeout, late 0x123 dropped while idle, then c1 gets its own data
      walk(1, 0, rnd48(), rnd48(), rnd48(), 0, 1, 0, 1, 0, 0);
      send_junk();
      walk(0, 1, rnd48(), 48'h3000, 48'h5A5A, 0, 2, 0, 0, 0, 0);
      // timeout, late response lands inside the next WAIT and is dropped there
      walk(0, 1, rnd48(), rnd48(), rnd48(), 2, 1, 0, 1, 0, 0);
      walk(1, 0, rnd48(), rnd48(), 48'hBEEF, 0, 2, 0, 0, 1, 0);
      // response in the very last WAIT cycle still beats the timeout
      walk(1, 0, rnd48(), rnd48(), 48'h7777, 0, TMO + 1, 0, 0, 0, 0);
      // bus error on client 1
      walk(0, 1, rnd48(), rnd48(), 48'hFFFF, 0, 1, 1, 0, 0, 0);
      // back-pressure for 20 cycles
      walk(1, 0, rnd48(), rnd48(), 48'h4242, 20, 1, 0, 0, 0, 0);
      // walker abandons its request while pending: no pulse
      walk(1, 0, rnd48(), rnd48(), 48'h9999, 0, 3, 0, 0, 0, 1);
      // leave a stale flag behind, reset mid-walk, then a clean walk must not be dropped
      walk(1, 0, rnd48(), rnd48(), rnd48(), 0, 1, 0, 1, 0, 0);
      reset_mid();
      walk(1, 0, 48'h2000, rnd48(), 48'h600D, 0, 1, 0, 0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         r    = $urandom_range(1, 3);
         bp   = $urandom_range(0, 3);
         dly  = $urandom_range(1, 4);
         err  = ($urandom_range(0, 7) == 0);
         tmo  = !err && ($urandom_range(0, 9) == 0);
         junk = m_stale && ($urandom_range(0, 1) == 1);
         if (m_stale && !junk) send_junk();
         walk(r[0], r[1], rnd48(), rnd48(), rnd48(), bp, dly, err, tmo, junk, 0);
      end
      if (m_stale) send_junk();

      c0_mem_read = 1'b0;
      c1_mem_read = 1'b0;
      repeat (4) step();
      check("queue_drained", exp_q.size(), 0);
      check("final_idle", busy, 1'b0);
      finish_test();
   end

endmodule
